// File: rtl/psk_symbol_mapper_if.sv
// ---------------------------------------------------------------------------
// psk_symbol_mapper_if.sv
//
// Purpose:
//   Stream interfaces used around the PSK symbol mapper.
//   psk_sym_if : AXIS-style symbol stream into the mapper
//                (tdata = symbol bits, tuser = is_bpsk, tlast = end of packet).
//   psk_iq_if  : AXIS-style I/Q sample stream out of the mapper
//                (i/q = signed samples, tuser = is_bpsk, tlast = end of packet).
//
// Modports:
//   master : drives payload and tvalid, receives tready.
//   slave  : receives payload and tvalid, drives tready.
// ---------------------------------------------------------------------------

interface psk_sym_if #(
    parameter int IN_WIDTH = 8
);
    logic [IN_WIDTH-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;
    logic                tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

interface psk_iq_if #(
    parameter int IQ_WIDTH = 16
);
    logic signed [IQ_WIDTH-1:0] i;
    logic signed [IQ_WIDTH-1:0] q;
    logic                       tvalid;
    logic                       tready;
    logic                       tlast;
    logic                       tuser;

    modport master (output i, output q, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  i, input  q, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/psk_symbol_mapper.sv
// ---------------------------------------------------------------------------
// psk_symbol_mapper.sv
//
// Purpose:
//   Maps one symbol beat per clock to signed I/Q baseband samples for the
//   pulse-shaping / DUC stage. BPSK (tuser=1) places +/-BPSK_AMP on I with
//   Q=0; QPSK (tuser=0) uses Gray mapping at +/-QPSK_AMP on both rails.
//   A registered output stage plus one skid register give full AXIS
//   backpressure with a registered s_tready. Packet boundaries are tracked
//   to report accepted-symbol count and mid-packet input underruns.
//
// Optional feature:
//   Define PSK_DIFF_ENC_EN to enable differential encoding ahead of the
//   mapper. The reference phase restarts at 0 on the first beat of each
//   packet and on reset. Without the macro, mapping is absolute.
//
// Ports:
//   clk           symbol clock
//   rst           synchronous reset, active-high
//   s_axis        symbol stream in  (tdata, tvalid, tready, tlast, tuser)
//   m_axis        I/Q stream out    (i, q, tvalid, tready, tlast, tuser)
//   pkt_done      one-cycle pulse after the m_tlast beat transfers
//   sym_cnt       symbols accepted in the current packet (wraps at 16 bits)
//   underrun_cnt  saturating count of mid-packet cycles with no input
// ---------------------------------------------------------------------------

module psk_symbol_mapper #(
    parameter int IN_WIDTH = 8,
    parameter int IQ_WIDTH = 16,
    parameter int BPSK_AMP = 8191,
    parameter int QPSK_AMP = 5792
) (
    input  logic        clk,
    input  logic        rst,
    psk_sym_if.slave    s_axis,
    psk_iq_if.master    m_axis,
    output logic        pkt_done,
    output logic [15:0] sym_cnt,
    output logic [7:0]  underrun_cnt
);

    localparam logic [IQ_WIDTH-1:0] BPSK_POS = IQ_WIDTH'(BPSK_AMP);
    localparam logic [IQ_WIDTH-1:0] BPSK_NEG = -BPSK_POS;
    localparam logic [IQ_WIDTH-1:0] QPSK_POS = IQ_WIDTH'(QPSK_AMP);
    localparam logic [IQ_WIDTH-1:0] QPSK_NEG = -QPSK_POS;

    typedef struct packed {
        logic [IQ_WIDTH-1:0] i;
        logic [IQ_WIDTH-1:0] q;
        logic                last;
        logic                user;
    } beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state;

    beat_t  new_beat;
    beat_t  out_beat;
    beat_t  skid_beat;
    logic   out_valid;
    logic   skid_valid;
    logic   skid_valid_next;
    logic   s_tready_r;
    logic   in_xfer;
    logic   out_xfer;
    logic   out_free;
    logic   clear_pending;

    // Only the low dibit of tdata carries symbol information.
    logic   unused_tdata_bits;
    assign unused_tdata_bits = ^s_axis.tdata[IN_WIDTH-1:2];

    assign in_xfer  = s_axis.tvalid & s_tready_r;
    assign out_xfer = out_valid & m_axis.tready;
    // The output register can take a new beat when empty or draining now.
    assign out_free = ~out_valid | out_xfer;

`ifdef PSK_DIFF_ENC_EN
    logic [1:0] phase;
    logic [1:0] base_phase;
    logic [1:0] next_phase;
    logic [1:0] gray_dec;
    logic       bpsk_p;
`endif

    // Symbol-to-sample mapping on the input side, so the result is ready to
    // be registered into either the output or the skid slot. In the
    // differential build the phase restarts at 0 for the first beat of a
    // packet (state still IDLE), and BPSK works on phase bit 1 so a mode
    // switch mid-packet carries the phase across.
    always_comb begin
        new_beat      = '0;
        new_beat.last = s_axis.tlast;
        new_beat.user = s_axis.tuser;
`ifdef PSK_DIFF_ENC_EN
        base_phase = (state == IDLE) ? 2'd0 : phase;
        bpsk_p     = 1'b0;
        next_phase = base_phase;
        case (s_axis.tdata[1:0])
            2'b00:   gray_dec = 2'd0;
            2'b01:   gray_dec = 2'd1;
            2'b11:   gray_dec = 2'd2;
            default: gray_dec = 2'd3;
        endcase
        if (s_axis.tuser) begin
            bpsk_p     = base_phase[1] ^ s_axis.tdata[0];
            next_phase = {bpsk_p, base_phase[0]};
            new_beat.i = bpsk_p ? BPSK_NEG : BPSK_POS;
            new_beat.q = '0;
        end else begin
            next_phase = base_phase + gray_dec;
            // Phase 0..3 -> (+,+), (-,+), (-,-), (+,-)
            new_beat.i = (next_phase[1] ^ next_phase[0]) ? QPSK_NEG : QPSK_POS;
            new_beat.q = next_phase[1] ? QPSK_NEG : QPSK_POS;
        end
`else
        if (s_axis.tuser) begin
            new_beat.i = s_axis.tdata[0] ? BPSK_NEG : BPSK_POS;
            new_beat.q = '0;
        end else begin
            new_beat.i = s_axis.tdata[1] ? QPSK_NEG : QPSK_POS;
            new_beat.q = s_axis.tdata[0] ? QPSK_NEG : QPSK_POS;
        end
`endif
    end

    // Skid occupancy after this edge. When the output frees up the skid beat
    // moves forward; otherwise an accepted beat parks in the skid slot.
    always_comb begin
        if (out_free) begin
            skid_valid_next = skid_valid & in_xfer;
        end else begin
            skid_valid_next = skid_valid | in_xfer;
        end
    end

    // Output and skid registers. The skid beat always goes out before any
    // newly accepted beat so ordering is preserved; s_tready is registered
    // as the inverse of the next skid occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
            s_tready_r <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            pkt_done   <= out_xfer & out_beat.last;
            skid_valid <= skid_valid_next;
            s_tready_r <= ~skid_valid_next;
            if (out_free) begin
                if (skid_valid) begin
                    out_beat  <= skid_beat;
                    out_valid <= 1'b1;
                end else if (in_xfer) begin
                    out_beat  <= new_beat;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (in_xfer && (!out_free || skid_valid)) begin
                skid_beat <= new_beat;
            end
        end
    end

    // Packet FSM and counters, driven by the input side. sym_cnt shows the
    // final count for one cycle after the tlast transfer, then clears; a
    // new first beat in that clear cycle restarts the count at 1. Gaps are
    // only counted while a packet is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sym_cnt       <= 16'd0;
            clear_pending <= 1'b0;
            underrun_cnt  <= 8'd0;
`ifdef PSK_DIFF_ENC_EN
            phase         <= 2'd0;
`endif
        end else begin
            if (in_xfer) begin
                sym_cnt       <= (clear_pending ? 16'd0 : sym_cnt) + 16'd1;
                clear_pending <= s_axis.tlast;
`ifdef PSK_DIFF_ENC_EN
                phase         <= next_phase;
`endif
            end else begin
                if (clear_pending) begin
                    sym_cnt <= 16'd0;
                end
                clear_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in_xfer && !s_axis.tlast) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (in_xfer && s_axis.tlast) begin
                        state <= IDLE;
                    end else if (!s_axis.tvalid && (underrun_cnt != 8'hFF)) begin
                        underrun_cnt <= underrun_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_axis.tready = s_tready_r;
    assign m_axis.i      = out_beat.i;
    assign m_axis.q      = out_beat.q;
    assign m_axis.tlast  = out_beat.last;
    assign m_axis.tuser  = out_beat.user;
    assign m_axis.tvalid = out_valid;

endmodule
